// File: rtl/dec139_select_sequencer.sv
// Select-code sequencer for a 74x139 dual 2-to-4 decoder: sweeps {C,B,A} through
// all eight codes in binary or Gray order, holding each code for a latched dwell.
module dec139_select_sequencer #(
  parameter int DWELL_W = 8,
  parameter int CODE_W  = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               STOP,
  input  logic               LOOP,
  input  logic               GRAY,
  input  logic [DWELL_W-1:0] DWELL,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               VALID,
  output logic               STEP,
  output logic               BUSY,
  output logic               DONE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CODE_W-1:0]  LAST_IDX = '1;
  localparam logic [DWELL_W-1:0] ONE_D    = DWELL_W'(1);

  function automatic logic [CODE_W-1:0] f_map(input logic [CODE_W-1:0] idx,
                                               input logic              gray);
    return gray ? (idx ^ (idx >> 1)) : idx;
  endfunction

  logic [1:0]         r_state, w_state;
  logic [CODE_W-1:0]  r_index, w_index;
  logic [DWELL_W-1:0] r_cnt,   w_cnt;
  logic [DWELL_W-1:0] r_dwell, w_dwell;
  logic               r_loop,  w_loop;
  logic               r_gray,  w_gray;
  logic [CODE_W-1:0]  r_code,  w_code;
  logic               r_valid, w_valid;
  logic               r_step,  w_step;
  logic               r_busy,  w_busy;
  logic               r_done,  w_done;

  // Outputs are computed for the next cycle and registered, so every port is a flop.
  always_comb begin
    w_state = r_state;
    w_index = r_index;
    w_cnt   = r_cnt;
    w_dwell = r_dwell;
    w_loop  = r_loop;
    w_gray  = r_gray;
    w_valid = 1'b0;
    w_step  = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START && !STOP) begin
          w_dwell = (DWELL == '0) ? ONE_D : DWELL;
          w_loop  = LOOP;
          w_gray  = GRAY;
          w_index = '0;
          w_cnt   = w_dwell - ONE_D;
          w_state = S_RUN;
          w_valid = 1'b1;
          w_step  = 1'b1;
          w_busy  = 1'b1;
        end
      end
      S_RUN: begin
        if (STOP) begin
          w_state = S_IDLE;
          w_index = '0;
          w_cnt   = '0;
        end else begin
          w_valid = 1'b1;
          w_busy  = 1'b1;
          if (r_cnt != '0) begin
            w_cnt = r_cnt - ONE_D;
          end else if (r_index != LAST_IDX) begin
            w_index = r_index + CODE_W'(1);
            w_cnt   = r_dwell - ONE_D;
            w_step  = 1'b1;
          end else if (r_loop) begin
            w_index = '0;
            w_cnt   = r_dwell - ONE_D;
            w_step  = 1'b1;
          end else begin
            w_state = S_FIN;
            w_index = '0;
            w_valid = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end
        end
      end
      S_FIN: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
        w_index = '0;
        w_cnt   = '0;
      end
    endcase
    w_code = w_valid ? f_map(w_index, w_gray) : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_cnt   <= '0;
      r_dwell <= ONE_D;
      r_loop  <= 1'b0;
      r_gray  <= 1'b0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_index <= w_index;
      r_cnt   <= w_cnt;
      r_dwell <= w_dwell;
      r_loop  <= w_loop;
      r_gray  <= w_gray;
      r_code  <= w_code;
      r_valid <= w_valid;
      r_step  <= w_step;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign A     = r_code[0];
  assign B     = r_code[1];
  assign C     = r_code[2];
  assign VALID = r_valid;
  assign STEP  = r_step;
  assign BUSY  = r_busy;
  assign DONE  = r_done;

endmodule

// File: tb/tb_dec139_select_sequencer.sv
// Bench for dec139_select_sequencer: cycle vector table, directed corner sequences,
// and randomized traffic against an arithmetic model of the sweep timeline.
module tb_dec139_select_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START, STOP, LOOP, GRAY;
  logic [7:0] DWELL;
  logic       A, B, C, VALID, STEP, BUSY, DONE;

  int total = 0;
  int bad   = 0;

  dec139_select_sequencer #(.DWELL_W(8), .CODE_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .LOOP(LOOP),
    .GRAY(GRAY), .DWELL(DWELL), .A(A), .B(B), .C(C), .VALID(VALID),
    .STEP(STEP), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int outs();
    return int'({C, B, A, VALID, STEP, BUSY, DONE});
  endfunction

  // Reference: a sweep is a count n of RUN cycles since the start edge; the code
  // index is (n / D) mod 8, a new code starts when n is a multiple of D.
  bit m_act, m_fin, m_loop, m_gray;
  int m_n, m_D;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_act <= 1'b0; m_fin <= 1'b0; m_n <= 0; m_D <= 1;
    end else if (m_fin) begin
      m_fin <= 1'b0;
    end else if (!m_act) begin
      if (START && !STOP) begin
        m_act  <= 1'b1;
        m_n    <= 0;
        m_D    <= (DWELL == 8'd0) ? 1 : int'(DWELL);
        m_loop <= LOOP;
        m_gray <= GRAY;
      end
    end else if (STOP) begin
      m_act <= 1'b0;
    end else begin
      m_n <= m_n + 1;
      if (!m_loop && (m_n + 1 == 8 * m_D)) begin
        m_act <= 1'b0;
        m_fin <= 1'b1;
      end
    end
  end

  function automatic int model_out();
    int idx, code, step;
    if (m_fin) return 1;
    if (!m_act) return 0;
    idx  = (m_n / m_D) % 8;
    code = m_gray ? (idx ^ (idx >> 1)) : idx;
    step = ((m_n % m_D) == 0) ? 1 : 0;
    return (code << 4) | 8 | (step << 2) | 2;
  endfunction

  always @(negedge CLK) chk("model", outs(), model_out());

  typedef struct {
    logic       start;
    logic       stop;
    logic [2:0] code;
    logic       valid, step, busy, done;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic st, input logic sp, input logic [2:0] cd,
                              input logic v, input logic s, input logic b, input logic d);
    vec_t r;
    r.start = st; r.stop = sp; r.code = cd; r.valid = v; r.step = s; r.busy = b; r.done = d;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sweep_count(input int dw, input logic gr, input int budget,
                             input int exp_busy, input int exp_done_at, input string nm);
    int nbusy, nstep, done_at;
    nbusy = 0; nstep = 0; done_at = 0;
    DWELL = 8'(dw); GRAY = gr; LOOP = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (BUSY) nbusy++;
      if (STEP) nstep++;
      if (DONE) begin
        done_at = k;
        break;
      end
      tick();
    end
    chk({nm, "_busy"}, nbusy, exp_busy);
    chk({nm, "_steps"}, nstep, 8);
    chk({nm, "_done_at"}, done_at, exp_done_at);
    tick();
    chk({nm, "_after"}, outs(), 0);
  endtask

  initial begin
    int ndone;
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0; LOOP = 1'b0; GRAY = 1'b0; DWELL = 8'd1;

    tbl[0]  = mk(1, 1, 3'b000, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 3'b000, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 3'b000, 1, 1, 1, 0);
    tbl[3]  = mk(1, 0, 3'b001, 1, 1, 1, 0);
    tbl[4]  = mk(0, 0, 3'b011, 1, 1, 1, 0);
    tbl[5]  = mk(0, 0, 3'b010, 1, 1, 1, 0);
    tbl[6]  = mk(0, 0, 3'b110, 1, 1, 1, 0);
    tbl[7]  = mk(0, 0, 3'b111, 1, 1, 1, 0);
    tbl[8]  = mk(0, 0, 3'b101, 1, 1, 1, 0);
    tbl[9]  = mk(0, 0, 3'b100, 1, 1, 1, 0);
    tbl[10] = mk(0, 0, 3'b000, 0, 0, 0, 1);
    tbl[11] = mk(1, 0, 3'b000, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 3'b000, 1, 1, 1, 0);
    tbl[13] = mk(0, 1, 3'b000, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 3'b000, 0, 0, 0, 0);

    #2;
    chk("reset_outs", outs(), 0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    chk("idle_after_reset", outs(), 0);

    DWELL = 8'd0; GRAY = 1'b1; LOOP = 1'b0;
    for (int i = 0; i < 15; i++) begin
      START = tbl[i].start;
      STOP  = tbl[i].stop;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          int'({tbl[i].code, tbl[i].valid, tbl[i].step, tbl[i].busy, tbl[i].done}));
    end
    START = 1'b0; STOP = 1'b0;
    tick();

    sweep_count(1, 1'b0, 20, 8, 9, "d1");
    sweep_count(100, 1'b0, 900, 800, 801, "d100");
    sweep_count(255, 1'b1, 2100, 2040, 2041, "d255");

    // Loop wrap after code 7, then STOP while code 3 is showing.
    DWELL = 8'd2; LOOP = 1'b1; GRAY = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("loop_last", outs(), int'({3'b111, 4'b1010}));
    tick();
    chk("loop_wrap", outs(), int'({3'b000, 4'b1110}));
    for (int k = 0; k < 6; k++) tick();
    chk("loop_idx3", outs(), int'({3'b011, 4'b1110}));
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("stop_idle", outs(), 0);
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (DONE) ndone++;
    end
    chk("stop_no_done", ndone, 0);

    // Asynchronous reset mid-sweep while code 5 is held.
    DWELL = 8'd3; LOOP = 1'b0; GRAY = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ({C, B, A} == 3'b101) break;
      tick();
    end
    chk("reach_idx5", int'({C, B, A}), 5);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_reset", outs(), 0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("idle_after_async", outs(), 0);

    for (int k = 0; k < 3000; k++) begin
      START = ($urandom % 4) == 0;
      STOP  = ($urandom % 24) == 0;
      LOOP  = ($urandom % 4) == 0;
      GRAY  = $urandom % 2;
      DWELL = 8'($urandom % 5);
      tick();
    end
    START = 1'b0; STOP = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dec139_select_sequencer.md
Name: dec139_select_sequencer

Overview:
Upstream stimulus/scan stage for the v74x139_a dual 2-to-4 decoder. It drives the decoder's A, B, C select inputs through all eight codes in a timed sweep, holding each code for a programmable number of clocks. It uses a start/done handshake so a controller can run single sweeps or continuous scans. Sweep order is selectable between binary and Gray.

Parameters:
DWELL_W, 8, width of the DWELL input and the internal dwell counter
CODE_W, 3, width of the code index; fixed at 3 for the 74x139 pairing, not to be overridden

Ports:
CLK  in  1  system clock, rising-edge
RST_N  in  1  asynchronous active-low reset
START  in  1  request sweep; sampled only in IDLE
STOP  in  1  abort sweep; sampled in RUN
LOOP  in  1  1 = restart at code 0 after code 7; latched at start
GRAY  in  1  1 = Gray-code order; latched at start
DWELL  in  DWELL_W  clocks each code is held; latched at start; 0 is treated as 1
A  out  1  select bit 0 (LSB) to decoder
B  out  1  select bit 1 to decoder
C  out  1  select bit 2 (MSB) to decoder
VALID  out  1  A/B/C carry a sweep code
STEP  out  1  one-cycle pulse on the first cycle of each new code
BUSY  out  1  sweep in progress
DONE  out  1  one-cycle pulse when a one-shot sweep completes

Behaviour:
- Reset, async on RST_N=0:
  - state = IDLE; index = 0; counter = 0.
  - A = B = C = 0; VALID = STEP = BUSY = DONE = 0.
  - Applies immediately, including mid-sweep.
- All outputs are registered.
- States: IDLE, RUN, FIN.
- IDLE:
  - A, B, C = 0; VALID = BUSY = 0.
  - If START=1 and STOP=0 at the clock edge:
    - Latch D = max(DWELL, 1), LOOP and GRAY.
    - index = 0; counter = D-1; enter RUN.
    - In the first RUN cycle: VALID = 1, BUSY = 1, STEP = 1, code = 000.
  - START=1 with STOP=1: stay in IDLE.
- Code mapping:
  - GRAY=0: {C,B,A} = index.
  - GRAY=1: {C,B,A} = index ^ (index >> 1).
  - Order for GRAY=1: 000, 001, 011, 010, 110, 111, 101, 100.
- RUN, evaluated each edge in this priority order:
  - STOP=1: next cycle enter IDLE; outputs go to 000; VALID = BUSY = 0; DONE is not pulsed.
  - counter != 0: counter decrements; code holds; STEP = 0.
  - counter == 0 and index < 7: index increments; counter = D-1; STEP = 1 next cycle.
  - counter == 0, index == 7, LOOP=1: index = 0; counter = D-1; STEP = 1; BUSY stays 1.
  - counter == 0, index == 7, LOOP=0: enter FIN.
- Hold time: each code is held exactly D cycles. A one-shot sweep occupies 8*D RUN cycles.
- FIN, exactly one cycle:
  - DONE = 1; VALID = BUSY = 0; A, B, C = 000.
  - START is ignored.
  - Next cycle returns to IDLE; a START in that cycle is accepted.
- Ignored inputs:
  - START during RUN or FIN is ignored.
  - DWELL, LOOP and GRAY changes during RUN have no effect.
- D arithmetic: unsigned DWELL_W bits. Maximum D = 2^DWELL_W - 1, no overflow.
- LOOP=1 with STOP never asserted: sweep continues indefinitely; DONE is never pulsed.

Test Plan:
- One-shot, DWELL=1, GRAY=0, START pulse → {C,B,A} = 000..111 on 8 consecutive cycles, STEP high on all 8, BUSY high 8 cycles, then DONE for 1 cycle, outputs return to 000. Downstream v74x139_a Y1/Y2 patterns are checked per code.
- DWELL=100, GRAY=0 → each code held 100 cycles, STEP once per code, DONE at cycle 801 after the start edge.
- DWELL=0, GRAY=1 → behaves as D=1; order 000, 001, 011, 010, 110, 111, 101, 100; DONE after 8 RUN cycles.
- LOOP=1, DWELL=2: after code 111 the next code is 000 with STEP=1. STOP asserted during index 3 → next cycle IDLE, VALID=0, DONE never asserted.
- RST_N low mid-sweep at index 5 → A=B=C=0 and VALID=BUSY=STEP=DONE=0 with no clock edge. After release, state is IDLE.
- START and STOP both high in IDLE → no sweep. START during RUN → no restart, index unaffected. START in FIN cycle → ignored; START one cycle later → new sweep begins.
